// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// State encodings, PC arithmetic constants and the stage-valid bundle.
package pipe_ctrl_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_INC           = 32'd4;

   typedef enum logic [1:0] {
      PC_BOOT   = 2'd0,
      PC_RUN    = 2'd1,
      PC_DRAIN  = 2'd2,
      PC_HALTED = 2'd3
   } pc_state_e;

   typedef struct packed {
      logic if_id;
      logic id_ex;
      logic ex_mem;
      logic mem_wb;
   } stage_valid_t;

   // Instruction addresses are word aligned; the low two bits are dropped.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: owns the fetch PC, drives the instruction SRAM and the
// per-stage load enables/valids, handles freeze, drain/halt and retire count.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_if,
   input  logic            stall_id,
   input  logic            flush_id,
   input  logic            flush_ex,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            mem_wait,
   input  logic            halt_req,
   input  logic            resume,
   output logic            imem_en,
   output logic [XLEN-1:0] imem_addr,
   output logic [XLEN-1:0] if_pc,
   output logic            if_id_en,
   output logic            id_ex_en,
   output logic            ex_mem_en,
   output logic            mem_wb_en,
   output logic            if_id_valid,
   output logic            id_ex_valid,
   output logic            ex_mem_valid,
   output logic            mem_wb_valid,
   output logic            halted,
   output logic [XLEN-1:0] instret
);

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [XLEN-1:0] instret_q, instret_d;
   stage_valid_t    valid_q, valid_d;
   logic            halted_q, halted_d;
   logic            stall;
   logic [XLEN-1:0] target;

   assign stall  = stall_if | stall_id;
   assign target = align_pc(redirect_pc);

   // Next state, fetch control and enables; reset or mem_wait freezes all.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      instret_d  = instret_q;
      valid_d    = valid_q;
      halted_d   = halted_q;
      imem_en    = 1'b0;
      imem_addr  = fetch_pc_q;
      if_id_en   = 1'b0;
      id_ex_en   = 1'b0;
      ex_mem_en  = 1'b0;
      mem_wb_en  = 1'b0;

      if (!rst && !mem_wait) begin
         valid_d.id_ex  = (flush_ex || (stall && !flush_id)) ? 1'b0 : valid_q.if_id;
         valid_d.ex_mem = valid_q.id_ex;
         valid_d.mem_wb = valid_q.ex_mem;
         if (valid_q.mem_wb) instret_d = instret_q + XLEN'(1);

         case (state_q)
            PC_BOOT: begin
               imem_en       = 1'b1;
               imem_addr     = fetch_pc_q;
               resp_pc_d     = fetch_pc_q;
               fetch_pc_d    = fetch_pc_q + PC_INC;
               valid_d.if_id = 1'b0;
               if_id_en      = 1'b1;
               id_ex_en      = 1'b1;
               ex_mem_en     = 1'b1;
               mem_wb_en     = 1'b1;
               state_d       = PC_RUN;
            end
            PC_RUN: begin
               id_ex_en  = 1'b1;
               ex_mem_en = 1'b1;
               mem_wb_en = 1'b1;
               if (halt_req) begin
                  // The word on the SRAM output is not delivered; it is the resume point.
                  state_d    = PC_DRAIN;
                  fetch_pc_d = flush_id ? target : resp_pc_q;
                  if (flush_id || !stall) begin
                     if_id_en      = 1'b1;
                     valid_d.if_id = 1'b0;
                  end
               end else if (flush_id) begin
                  imem_en       = 1'b1;
                  imem_addr     = target;
                  resp_pc_d     = target;
                  fetch_pc_d    = target + PC_INC;
                  if_id_en      = 1'b1;
                  valid_d.if_id = 1'b0;
               end else if (!stall) begin
                  imem_en       = 1'b1;
                  imem_addr     = fetch_pc_q;
                  resp_pc_d     = fetch_pc_q;
                  fetch_pc_d    = fetch_pc_q + PC_INC;
                  if_id_en      = 1'b1;
                  valid_d.if_id = 1'b1;
               end
            end
            PC_DRAIN: begin
               id_ex_en  = 1'b1;
               ex_mem_en = 1'b1;
               mem_wb_en = 1'b1;
               if (flush_id) fetch_pc_d = target;
               if (flush_id || !stall) begin
                  if_id_en      = 1'b1;
                  valid_d.if_id = 1'b0;
               end
               if (valid_q == '0) state_d = PC_HALTED;
            end
            PC_HALTED: begin
               if (resume) state_d = PC_BOOT;
            end
            default: state_d = PC_BOOT;
         endcase

         halted_d = (state_d == PC_HALTED);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PC_BOOT;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         instret_q  <= '0;
         valid_q    <= '0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         instret_q  <= instret_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
      end
   end

   assign if_pc        = resp_pc_q;
   assign if_id_valid  = valid_q.if_id;
   assign id_ex_valid  = valid_q.id_ex;
   assign ex_mem_valid = valid_q.ex_mem;
   assign mem_wb_valid = valid_q.mem_wb;
   assign halted       = halted_q;
   assign instret      = instret_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle vector table plus a bounded
// halt/resume sequence.
module tb_pipe_ctrl;

   localparam logic [7:0] NONE = 8'h00;
   localparam logic [7:0] RST  = 8'h80;
   localparam logic [7:0] SIF  = 8'h40;
   localparam logic [7:0] SID  = 8'h20;
   localparam logic [7:0] FID  = 8'h10;
   localparam logic [7:0] FEX  = 8'h08;
   localparam logic [7:0] MW   = 8'h04;
   localparam logic [7:0] HR   = 8'h02;
   localparam logic [7:0] RS   = 8'h01;

   logic        clk;
   logic        rst, stall_if, stall_id, flush_id, flush_ex, mem_wait, halt_req, resume;
   logic [31:0] redirect_pc;
   logic        imem_en;
   logic [31:0] imem_addr, if_pc, instret;
   logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid;
   logic        halted;

   pipe_ctrl #(.RESET_PC(32'h0000_0100)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_if     (stall_if),
      .stall_id     (stall_id),
      .flush_id     (flush_id),
      .flush_ex     (flush_ex),
      .redirect_pc  (redirect_pc),
      .mem_wait     (mem_wait),
      .halt_req     (halt_req),
      .resume       (resume),
      .imem_en      (imem_en),
      .imem_addr    (imem_addr),
      .if_pc        (if_pc),
      .if_id_en     (if_id_en),
      .id_ex_en     (id_ex_en),
      .ex_mem_en    (ex_mem_en),
      .mem_wb_en    (mem_wb_en),
      .if_id_valid  (if_id_valid),
      .id_ex_valid  (id_ex_valid),
      .ex_mem_valid (ex_mem_valid),
      .mem_wb_valid (mem_wb_valid),
      .halted       (halted),
      .instret      (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  ctrl;
      logic [31:0] redir;
      logic        e_imem_en;
      logic [31:0] e_addr;
      logic [31:0] e_if_pc;
      logic [3:0]  e_valid;
      logic        e_halted;
      logic [31:0] e_instret;
      logic [3:0]  e_en;
      logic [3:0]  en_care;
   } vec_t;

   vec_t vecs[$];
   vec_t v;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   waited;

   function automatic vec_t mk(input logic [7:0] c, input logic [31:0] r,
                               input logic en, input logic [31:0] a,
                               input logic [31:0] pc, input logic [3:0] val,
                               input logic h, input logic [31:0] ir,
                               input logic [3:0] e, input logic [3:0] care);
      vec_t t;
      t.ctrl = c;  t.redir = r;  t.e_imem_en = en;  t.e_addr = a;
      t.e_if_pc = pc;  t.e_valid = val;  t.e_halted = h;  t.e_instret = ir;
      t.e_en = e;  t.en_care = care;
      return t;
   endfunction

   task automatic drive(input logic [7:0] c, input logic [31:0] r);
      rst         = c[7];
      stall_if    = c[6];
      stall_id    = c[5];
      flush_id    = c[4];
      flush_ex    = c[3];
      mem_wait    = c[2];
      halt_req    = c[1];
      resume      = c[0];
      redirect_pc = r;
   endtask

   task automatic check(input string name, input int row,
                        input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   initial begin
      drive(RST, 32'h0);

      // ctrl, redirect, imem_en, imem_addr, if_pc, {if_id,id_ex,ex_mem,mem_wb}, halted, instret, enables, enable care mask
      vecs.push_back(mk(RST,       32'h0,   1'b0, 32'h0,   32'h100, 4'b0000, 1'b0, 32'd0, 4'b0000, 4'b1111));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h100, 32'h100, 4'b0000, 1'b0, 32'd0, 4'b0000, 4'b0000));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h104, 32'h100, 4'b0000, 1'b0, 32'd0, 4'b1111, 4'b1111));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h108, 32'h104, 4'b1000, 1'b0, 32'd0, 4'b1111, 4'b1111));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h10C, 32'h108, 4'b1100, 1'b0, 32'd0, 4'b1111, 4'b1111));
      // stall with flush_ex at fetch_pc 110
      vecs.push_back(mk(SIF|SID|FEX, 32'h0, 1'b0, 32'h0,   32'h10C, 4'b1110, 1'b0, 32'd0, 4'b0011, 4'b1011));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h110, 32'h10C, 4'b1011, 1'b0, 32'd0, 4'b1111, 4'b1111));
      // redirect to 200
      vecs.push_back(mk(FID,       32'h200, 1'b1, 32'h200, 32'h110, 4'b1101, 1'b0, 32'd1, 4'b0011, 4'b0011));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h204, 32'h200, 4'b0110, 1'b0, 32'd2, 4'b1111, 4'b1111));
      // mem_wait freeze with a pending redirect
      vecs.push_back(mk(MW|FID,    32'h300, 1'b0, 32'h0,   32'h204, 4'b1011, 1'b0, 32'd2, 4'b0000, 4'b1111));
      vecs.push_back(mk(MW|FID,    32'h300, 1'b0, 32'h0,   32'h204, 4'b1011, 1'b0, 32'd2, 4'b0000, 4'b1111));
      vecs.push_back(mk(MW|FID,    32'h300, 1'b0, 32'h0,   32'h204, 4'b1011, 1'b0, 32'd2, 4'b0000, 4'b1111));
      vecs.push_back(mk(FID,       32'h300, 1'b1, 32'h300, 32'h204, 4'b1011, 1'b0, 32'd2, 4'b0011, 4'b0011));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h304, 32'h300, 4'b0101, 1'b0, 32'd3, 4'b1111, 4'b1111));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h308, 32'h304, 4'b1010, 1'b0, 32'd4, 4'b1111, 4'b1111));
      // halt with three valid instructions in flight
      vecs.push_back(mk(HR,        32'h0,   1'b0, 32'h0,   32'h308, 4'b1101, 1'b0, 32'd4, 4'b0011, 4'b0011));
      vecs.push_back(mk(HR,        32'h0,   1'b0, 32'h0,   32'h308, 4'b0110, 1'b0, 32'd5, 4'b0011, 4'b0011));
      vecs.push_back(mk(NONE,      32'h0,   1'b0, 32'h0,   32'h308, 4'b0011, 1'b0, 32'd5, 4'b0011, 4'b0011));
      vecs.push_back(mk(NONE,      32'h0,   1'b0, 32'h0,   32'h308, 4'b0001, 1'b0, 32'd6, 4'b0011, 4'b0011));
      vecs.push_back(mk(NONE,      32'h0,   1'b0, 32'h0,   32'h308, 4'b0000, 1'b0, 32'd7, 4'b0000, 4'b0000));
      vecs.push_back(mk(NONE,      32'h0,   1'b0, 32'h0,   32'h308, 4'b0000, 1'b1, 32'd7, 4'b0000, 4'b1111));
      vecs.push_back(mk(RS,        32'h0,   1'b0, 32'h0,   32'h308, 4'b0000, 1'b1, 32'd7, 4'b0000, 4'b1111));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h308, 32'h308, 4'b0000, 1'b0, 32'd7, 4'b0000, 4'b0000));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h30C, 32'h308, 4'b0000, 1'b0, 32'd7, 4'b1111, 4'b1111));
      // PC wrap and misaligned redirect target
      vecs.push_back(mk(FID, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h30C, 4'b1000, 1'b0, 32'd7, 4'b0011, 4'b0011));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h0,   32'hFFFF_FFFC, 4'b0100, 1'b0, 32'd7, 4'b1111, 4'b1111));
      vecs.push_back(mk(FID,       32'h403, 1'b1, 32'h400, 32'h0,   4'b1010, 1'b0, 32'd7, 4'b0011, 4'b0011));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h404, 32'h400, 4'b0101, 1'b0, 32'd7, 4'b1111, 4'b1111));
      // flush beats stall; resume outside HALTED is ignored
      vecs.push_back(mk(SIF|FID,   32'h500, 1'b1, 32'h500, 32'h404, 4'b1010, 1'b0, 32'd8, 4'b0011, 4'b0011));
      vecs.push_back(mk(RS,        32'h0,   1'b1, 32'h504, 32'h500, 4'b0101, 1'b0, 32'd8, 4'b1111, 4'b1111));
      // reset mid-operation; halt_req ignored in BOOT
      vecs.push_back(mk(RST,       32'h0,   1'b0, 32'h0,   32'h504, 4'b1010, 1'b0, 32'd9, 4'b0000, 4'b1111));
      vecs.push_back(mk(HR,        32'h0,   1'b1, 32'h100, 32'h100, 4'b0000, 1'b0, 32'd0, 4'b0000, 4'b0000));
      vecs.push_back(mk(NONE,      32'h0,   1'b1, 32'h104, 32'h100, 4'b0000, 1'b0, 32'd0, 4'b1111, 4'b1111));

      repeat (2) @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         v = vecs[i];
         drive(v.ctrl, v.redir);
         @(negedge clk);
         check("imem_en", i, 32'(imem_en), 32'(v.e_imem_en));
         if (v.e_imem_en) check("imem_addr", i, imem_addr, v.e_addr);
         check("if_pc", i, if_pc, v.e_if_pc);
         check("valids", i, 32'({if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid}),
               32'(v.e_valid));
         check("halted", i, 32'(halted), 32'(v.e_halted));
         check("instret", i, instret, v.e_instret);
         if (v.en_care != 4'b0000)
            check("enables", i,
                  32'({if_id_en, id_ex_en, ex_mem_en, mem_wb_en} & v.en_care),
                  32'(v.e_en & v.en_care));
         @(posedge clk);
         #1;
      end

      // Halt with one instruction in IF/ID and 104 on the SRAM output, then resume.
      drive(HR, 32'h0);
      @(posedge clk);
      #1;
      drive(NONE, 32'h0);
      waited = 0;
      while (!halted && waited < 20) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("halt_wait", 100, 32'(halted), 32'(1'b1));
      check("halt_instret", 100, instret, 32'd1);
      drive(RS, 32'h0);
      @(posedge clk);
      #1;
      drive(NONE, 32'h0);
      @(negedge clk);
      check("resume_en", 101, 32'(imem_en), 32'(1'b1));
      check("resume_addr", 101, imem_addr, 32'h104);
      check("resume_halted", 101, 32'(halted), 32'(1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
